// File: rtl/ring_pkg.sv
// ring_pkg: shared state encoding and default sizing for the ring counter sequencer
package ring_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        COUNT    = 3'd2,
        PUBLISH  = 3'd3,
        WAIT_ACK = 3'd4
    } ring_state_t;
    localparam int RING_COUNT_BITS  = 17;
    localparam int RING_SYNC_STAGES = 2;
endpackage

// File: rtl/ring_sync.sv
// ring_sync: STAGES-deep single-bit synchronizer into the ring_clk domain
module ring_sync #(
    parameter int STAGES = 2
) (
    input  logic ring_clk,
    input  logic counter_resetb,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge ring_clk or negedge counter_resetb)
        if (!counter_resetb) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/ring_count_seq.sv
// ring_count_seq: gated ring_clk cycle counter with toggle-handshake result publish
module ring_count_seq
    import ring_pkg::*;
#(
    parameter int COUNT_BITS  = RING_COUNT_BITS,
    parameter int SYNC_STAGES = RING_SYNC_STAGES
) (
    input  logic                  ring_clk,
    input  logic                  counter_resetb,
    input  logic                  gate_i,
    input  logic                  meas_req_tgl_i,
    input  logic                  result_ack_tgl_i,
    output logic [COUNT_BITS-1:0] count_o,
    output logic                  overflow_o,
    output logic                  result_req_tgl_o,
    output logic                  busy_o
);
    ring_state_t state, state_nxt;
    logic gate_sync, req_sync, ack_sync, gate_d, req_d, ack_d;
    logic req_evt, ack_evt, gate_rise, pending, ovf, start;
    logic [COUNT_BITS-1:0] counter;

    ring_sync #(.STAGES(SYNC_STAGES)) u_gate_sync (.ring_clk(ring_clk), .counter_resetb(counter_resetb), .d(gate_i), .q(gate_sync));
    ring_sync #(.STAGES(SYNC_STAGES)) u_req_sync (.ring_clk(ring_clk), .counter_resetb(counter_resetb), .d(meas_req_tgl_i), .q(req_sync));
    ring_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (.ring_clk(ring_clk), .counter_resetb(counter_resetb), .d(result_ack_tgl_i), .q(ack_sync));

    assign req_evt   = req_sync ^ req_d;
    assign ack_evt   = ack_sync ^ ack_d;
    assign gate_rise = gate_sync & ~gate_d;
    assign start     = (state == IDLE) && (req_evt || pending);
    assign busy_o    = state != IDLE;

    always_ff @(posedge ring_clk or negedge counter_resetb)
        if (!counter_resetb) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     state_nxt = start ? ARM : IDLE;
            ARM:      state_nxt = gate_rise ? COUNT : ARM;
            COUNT:    state_nxt = gate_sync ? COUNT : PUBLISH;
            PUBLISH:  state_nxt = WAIT_ACK;
            WAIT_ACK: state_nxt = ack_evt ? IDLE : WAIT_ACK;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ring_clk or negedge counter_resetb)
        if (!counter_resetb) begin
            {gate_d, req_d, ack_d} <= '0;
            pending          <= 1'b0;
            counter          <= '0;
            ovf              <= 1'b0;
            count_o          <= '0;
            overflow_o       <= 1'b0;
            result_req_tgl_o <= 1'b0;
        end else begin
            {gate_d, req_d, ack_d} <= {gate_sync, req_sync, ack_sync};
            // requests arriving while busy collapse into a single pending slot
            pending <= (state == IDLE) ? 1'b0 : (pending | req_evt);
            if (start) counter <= '0;
            if (state == ARM && gate_rise) begin
                counter <= COUNT_BITS'(1);
                ovf     <= 1'b0;
            end
            if (state == COUNT && gate_sync) begin
                if (&counter) ovf <= 1'b1;
                else counter <= counter + COUNT_BITS'(1);
            end
            if (state == PUBLISH) begin
                count_o          <= counter;
                overflow_o       <= ovf;
                result_req_tgl_o <= ~result_req_tgl_o;
            end
        end
endmodule
